// File: rtl/stump_control_if.sv
// Control bundle between the Stump sequencer and the register bank/ALU/memory datapath.
// The master modport is the datapath side, and the slave modport is the sequencer.
interface stump_control_if #(
    parameter int unsigned CNT_W = 16
);
    logic [15:0]      ir;
    logic [3:0]       flags;
    logic             mem_ready;
    logic             fetch_st;
    logic             exec_st;
    logic             mem_st;
    logic             ir_en;
    logic             pc_inc;
    logic [2:0]       alu_func;
    logic             imm_sel;
    logic [1:0]       shift_op;
    logic             cc_en;
    logic             reg_write;
    logic [2:0]       reg_dest;
    logic             addr_latch;
    logic             addr_sel;
    logic             mem_req;
    logic             mem_wen;
    logic [CNT_W-1:0] retired;

    modport master (
        output ir, flags, mem_ready,
        input  fetch_st, exec_st, mem_st, ir_en, pc_inc, alu_func, imm_sel, shift_op, cc_en,
               reg_write, reg_dest, addr_latch, addr_sel, mem_req, mem_wen, retired
    );

    modport slave (
        input  ir, flags, mem_ready,
        output fetch_st, exec_st, mem_st, ir_en, pc_inc, alu_func, imm_sel, shift_op, cc_en,
               reg_write, reg_dest, addr_latch, addr_sel, mem_req, mem_wen, retired
    );
endinterface

// File: rtl/stump_control.sv
// Stump instruction sequencer: walks FETCH/EXECUTE/MEMORY, decodes IR into datapath
// strobes, evaluates branch conditions, and counts retired instructions.
module stump_control #(
    parameter int unsigned CNT_W = 16
) (
    input logic            clk,
    input logic            rst,
    stump_control_if.slave io_ctl
);
    typedef enum logic [1:0] {StIdle, StFetch, StExec, StMem} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;

    logic [2:0] w_op;
    logic       w_type;
    logic       w_s;
    logic [2:0] w_dst;
    logic [1:0] w_shift;

    assign w_op    = io_ctl.ir[15:13];
    assign w_type  = io_ctl.ir[12];
    assign w_s     = io_ctl.ir[11];
    assign w_dst   = io_ctl.ir[10:8];
    // Immediate forms carry no shift field; the low bits belong to the immediate.
    assign w_shift = w_type ? 2'b00 : io_ctl.ir[1:0];

    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, v, c;
        {n, z, v, c} = f;
        case (cc)
            4'h0:    cond_pass = 1'b1;
            4'h1:    cond_pass = 1'b0;
            4'h2:    cond_pass = ~(c | z);
            4'h3:    cond_pass = c | z;
            4'h4:    cond_pass = ~c;
            4'h5:    cond_pass = c;
            4'h6:    cond_pass = ~z;
            4'h7:    cond_pass = z;
            4'h8:    cond_pass = ~v;
            4'h9:    cond_pass = v;
            4'hA:    cond_pass = ~n;
            4'hB:    cond_pass = n;
            4'hC:    cond_pass = ~(n ^ v);
            4'hD:    cond_pass = n ^ v;
            4'hE:    cond_pass = ~((n ^ v) | z);
            default: cond_pass = (n ^ v) | z;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  w_state_next = StFetch;
            StFetch: if (io_ctl.mem_ready) w_state_next = StExec;
            StExec:  w_state_next = (w_op == 3'd6) ? StMem : StFetch;
            StMem:   if (io_ctl.mem_ready) w_state_next = StFetch;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        io_ctl.fetch_st   = 1'b0;
        io_ctl.exec_st    = 1'b0;
        io_ctl.mem_st     = 1'b0;
        io_ctl.ir_en      = 1'b0;
        io_ctl.pc_inc     = 1'b0;
        io_ctl.alu_func   = 3'b000;
        io_ctl.imm_sel    = 1'b0;
        io_ctl.shift_op   = 2'b00;
        io_ctl.cc_en      = 1'b0;
        io_ctl.reg_write  = 1'b0;
        io_ctl.reg_dest   = 3'd0;
        io_ctl.addr_latch = 1'b0;
        io_ctl.addr_sel   = 1'b0;
        io_ctl.mem_req    = 1'b0;
        io_ctl.mem_wen    = 1'b0;
        w_retire          = 1'b0;
        unique case (r_state)
            StFetch: begin
                io_ctl.fetch_st = 1'b1;
                io_ctl.mem_req  = 1'b1;
                io_ctl.ir_en    = io_ctl.mem_ready;
                io_ctl.pc_inc   = io_ctl.mem_ready;
            end
            StExec: begin
                io_ctl.exec_st = 1'b1;
                if (w_op == 3'd7) begin
                    io_ctl.imm_sel   = 1'b1;
                    io_ctl.reg_dest  = 3'd7;
                    io_ctl.reg_write = cond_pass(io_ctl.ir[11:8], io_ctl.flags);
                    w_retire         = 1'b1;
                end else if (w_op == 3'd6) begin
                    io_ctl.imm_sel    = w_type;
                    io_ctl.shift_op   = w_shift;
                    io_ctl.addr_latch = 1'b1;
                end else begin
                    io_ctl.alu_func  = w_op;
                    io_ctl.imm_sel   = w_type;
                    io_ctl.shift_op  = w_shift;
                    io_ctl.cc_en     = w_s;
                    io_ctl.reg_write = 1'b1;
                    io_ctl.reg_dest  = w_dst;
                    w_retire         = 1'b1;
                end
            end
            StMem: begin
                io_ctl.mem_st   = 1'b1;
                io_ctl.mem_req  = 1'b1;
                io_ctl.addr_sel = 1'b1;
                io_ctl.mem_wen  = w_s;
                if (io_ctl.mem_ready) begin
                    io_ctl.reg_write = ~w_s;
                    io_ctl.reg_dest  = w_s ? 3'd0 : w_dst;
                    w_retire         = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign io_ctl.retired = r_retired;
endmodule

// File: tb/tb_stump_control.sv
// Directed bench for stump_control: table of decode/branch vectors plus hand-written
// sequences for wait states, load/store and reset during a memory wait.
module tb_stump_control;
    localparam int unsigned CNT_W = 4;

    logic clk;
    logic rst;

    stump_control_if #(.CNT_W(CNT_W)) u_if ();

    stump_control #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_ctl (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ir;
        logic [3:0]  flags;
        logic [2:0]  e_alu;
        logic        e_imm;
        logic [1:0]  e_shift;
        logic        e_cc;
        logic        e_we;
        logic [2:0]  e_dest;
        logic        e_al;
    } vec_t;

    int         n_checks;
    int         n_fail;
    logic [CNT_W-1:0] exp_ret;
    vec_t       vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entry and exit: 1 time unit after an edge, with the DUT in FETCH.
    task automatic run_insn(input vec_t v);
        u_if.ir        = v.ir;
        u_if.flags     = v.flags;
        u_if.mem_ready = 1'b1;
        #1;
        check("fetch_st", u_if.fetch_st, 1);
        check("fetch ir_en", u_if.ir_en, 1);
        check("retired", u_if.retired, exp_ret);
        tick();
        check("exec_st", u_if.exec_st, 1);
        check("alu_func", u_if.alu_func, v.e_alu);
        check("imm_sel", u_if.imm_sel, v.e_imm);
        check("shift_op", u_if.shift_op, v.e_shift);
        check("cc_en", u_if.cc_en, v.e_cc);
        check("reg_write", u_if.reg_write, v.e_we);
        check("reg_dest", u_if.reg_dest, v.e_dest);
        check("addr_latch", u_if.addr_latch, v.e_al);
        check("exec mem_req", u_if.mem_req, 0);
        if (v.ir[15:13] == 3'd6) begin
            tick();
            check("mem_st", u_if.mem_st, 1);
        end
        tick();
        exp_ret++;
    endtask

    logic [15:0] masks[3];
    logic [3:0]  fpat[3];

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        exp_ret        = '0;
        rst            = 1'b1;
        u_if.ir        = 16'h0000;
        u_if.flags     = 4'h0;
        u_if.mem_ready = 1'b0;

        // Branch-taken masks, bit k = condition code k, for each flag pattern.
        fpat[0] = 4'b0000; masks[0] = 16'h5555;
        fpat[1] = 4'b0100; masks[1] = 16'h9599;
        fpat[2] = 4'b1001; masks[2] = 16'hA969;

        vecs.push_back('{16'h0A2C, 4'h0, 3'd0, 1'b0, 2'd0, 1'b1, 1'b1, 3'd2, 1'b0});
        vecs.push_back('{16'h2315, 4'h0, 3'd1, 1'b0, 2'd1, 1'b0, 1'b1, 3'd3, 1'b0});
        vecs.push_back('{16'h5C07, 4'h0, 3'd2, 1'b1, 2'd0, 1'b1, 1'b1, 3'd4, 1'b0});
        vecs.push_back('{16'h6D03, 4'h0, 3'd3, 1'b0, 2'd3, 1'b1, 1'b1, 3'd5, 1'b0});
        vecs.push_back('{16'h96FF, 4'h0, 3'd4, 1'b1, 2'd0, 1'b0, 1'b1, 3'd6, 1'b0});
        vecs.push_back('{16'hA702, 4'h0, 3'd5, 1'b0, 2'd2, 1'b0, 1'b1, 3'd7, 1'b0});
        vecs.push_back('{16'hC302, 4'h0, 3'd0, 1'b0, 2'd2, 1'b0, 1'b0, 3'd0, 1'b1});
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 16; c++) begin
                vecs.push_back('{{4'hE, c[3:0], 8'h5A}, fpat[p], 3'd0, 1'b1, 2'd0, 1'b0,
                                 masks[p][c], 3'd7, 1'b0});
            end
        end

        // Reset state
        #2;
        check("rst mem_req", u_if.mem_req, 0);
        check("rst fetch_st", u_if.fetch_st, 0);
        check("rst retired", u_if.retired, 0);
        tick();
        rst = 1'b0;
        #1;
        check("idle fetch_st", u_if.fetch_st, 0);
        check("idle mem_req", u_if.mem_req, 0);
        tick();
        check("first fetch", u_if.fetch_st, 1);

        // Fetch wait states: three not-ready cycles, then ready on the fourth
        u_if.ir = 16'h0A2C;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wait fetch_st", u_if.fetch_st, 1);
            check("wait ir_en", u_if.ir_en, 0);
            check("wait pc_inc", u_if.pc_inc, 0);
            tick();
        end
        u_if.mem_ready = 1'b1;
        #1;
        check("ready fetch_st", u_if.fetch_st, 1);
        check("ready ir_en", u_if.ir_en, 1);
        check("ready pc_inc", u_if.pc_inc, 1);
        tick();
        check("add cc_en", u_if.cc_en, 1);
        check("add reg_dest", u_if.reg_dest, 2);
        check("add retired pre", u_if.retired, 0);
        tick();
        exp_ret++;
        check("add retired", u_if.retired, exp_ret);

        foreach (vecs[i]) run_insn(vecs[i]);
        check("retired after table", u_if.retired, exp_ret);

        // Load with two memory wait cycles
        u_if.ir = 16'hD140;
        #1;
        tick();
        check("ld addr_latch", u_if.addr_latch, 1);
        check("ld imm_sel", u_if.imm_sel, 1);
        u_if.mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("ld wait mem_st", u_if.mem_st, 1);
            check("ld wait addr_sel", u_if.addr_sel, 1);
            check("ld wait mem_wen", u_if.mem_wen, 0);
            check("ld wait reg_write", u_if.reg_write, 0);
            check("ld wait retired", u_if.retired, exp_ret);
        end
        u_if.mem_ready = 1'b1;
        #1;
        check("ld rdy reg_write", u_if.reg_write, 1);
        check("ld rdy reg_dest", u_if.reg_dest, 1);
        check("ld rdy mem_wen", u_if.mem_wen, 0);
        tick();
        exp_ret++;
        check("ld back to fetch", u_if.fetch_st, 1);
        check("ld retired", u_if.retired, exp_ret);

        // Store with one wait cycle
        u_if.ir = 16'hD940;
        #1;
        tick();
        u_if.mem_ready = 1'b0;
        tick();
        check("st wait mem_wen", u_if.mem_wen, 1);
        check("st wait reg_write", u_if.reg_write, 0);
        u_if.mem_ready = 1'b1;
        #1;
        check("st rdy mem_wen", u_if.mem_wen, 1);
        check("st rdy reg_write", u_if.reg_write, 0);
        tick();
        exp_ret++;
        check("st retired", u_if.retired, exp_ret);

        // Reset asserted in the middle of a store wait
        tick();
        u_if.mem_ready = 1'b0;
        tick();
        check("pre-rst mem_wen", u_if.mem_wen, 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort mem_wen", u_if.mem_wen, 0);
        check("abort mem_req", u_if.mem_req, 0);
        check("abort mem_st", u_if.mem_st, 0);
        check("abort retired", u_if.retired, 0);
        tick();
        rst = 1'b0;
        #1;
        check("post-rst idle", u_if.fetch_st, 0);
        tick();
        check("post-rst fetch", u_if.fetch_st, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end
endmodule
